// File: rtl/serial_servo_multi_pkg.sv
// Shared definitions for the multi-channel serial servo controller:
// command FSM state encoding and the ASCII characters of the protocol.
package serial_servo_multi_pkg;

   typedef enum logic [2:0] {
      OCIOSO     = 3'd0,
      ESPERA_POS = 3'd1,
      APLICA     = 3'd2,
      ENVIA      = 3'd3,
      AGUARDA_TX = 3'd4
   } estado_t;

   localparam logic [7:0] ASCII_0 = 8'h30;
   localparam logic [7:0] ASCII_K = 8'h4B;
   localparam logic [7:0] ASCII_E = 8'h45;

endpackage

// File: rtl/serial_servo_multi_pwm_canal.sv
// One servo channel: a shadow width written by the command FSM, an active
// width that follows the shadow only at the period wrap, and the comparator
// against the shared PWM counter.
module pwm_canal
   import serial_servo_multi_pkg::*;
#(
   parameter int unsigned W        = 20,
   parameter int unsigned LARG_MIN = 50_000
) (
   input  logic         clock,
   input  logic         reset,
   input  logic [W-1:0] conta,
   input  logic         vira,
   input  logic         escreve,
   input  logic [W-1:0] largura,
   output logic         pwm
);

   logic [W-1:0] sombra;
   logic [W-1:0] ativa;

   // Shadow/active width registers and registered comparator output
   always_ff @(posedge clock or negedge reset) begin
      if (!reset) begin
         sombra <= W'(LARG_MIN);
         ativa  <= W'(LARG_MIN);
         pwm    <= 1'b0;
      end else begin
         if (escreve)
            sombra <= largura;
         if (vira)
            ativa <= sombra;
         // compare uses the width of the period the counter is in; at the
         // wrap edge the counter sits at its last value, so output goes low
         pwm <= (conta < ativa);
      end
   end

endmodule

// File: rtl/serial_servo_multi.sv
// Multi-channel servo controller driven by two-byte ASCII commands
// (channel digit, position digit) from an external serial receiver; answers
// 'K' or 'E' through an external serial transmitter.
module serial_servo_multi
   import serial_servo_multi_pkg::*;
#(
   parameter int unsigned N_CH          = 4,
   parameter int unsigned N_POS         = 8,
   parameter int unsigned N_BITS        = 7,
   parameter int unsigned PERIODO_CONTA = 1_000_000,
   parameter int unsigned LARG_MIN      = 50_000,
   parameter int unsigned LARG_PASSO    = 7_000,
   parameter int unsigned TIMEOUT       = 5_000_000
) (
   input  logic              clock,
   input  logic              reset,
   input  logic [N_BITS-1:0] rx_dado,
   input  logic              rx_fim,
   input  logic              rx_paridade_ok,
   input  logic              tx_pronto,
   output logic [N_BITS-1:0] tx_dado,
   output logic              tx_partida,
   output logic [N_CH-1:0]   pwm,
   output logic              erro,
   output logic [2:0]        db_canal,
   output logic [2:0]        db_estado
);

   localparam int unsigned W  = $clog2(PERIODO_CONTA);
   localparam int unsigned TW = $clog2(TIMEOUT + 1);

   localparam logic [N_BITS-1:0] C_0 = N_BITS'(ASCII_0);
   localparam logic [N_BITS-1:0] C_K = N_BITS'(ASCII_K);
   localparam logic [N_BITS-1:0] C_E = N_BITS'(ASCII_E);

   if (LARG_MIN + (N_POS - 1) * LARG_PASSO >= PERIODO_CONTA) begin : g_chk_largura
      $error("widest pulse does not fit in the PWM period");
   end

   estado_t         estado;
   logic [2:0]      canal;
   logic [3:0]      pos;
   logic [TW-1:0]   tempo;
   logic [W-1:0]    conta;
   logic            vira;
   logic [N_BITS-1:0] digito;
   logic            canal_ok;
   logic            pos_ok;
   logic            escreve;
   logic [W-1:0]    largura;

   assign vira      = (conta == W'(PERIODO_CONTA - 1));
   assign escreve   = (estado == APLICA);
   assign largura   = W'(LARG_MIN) + W'(pos) * W'(LARG_PASSO);
   assign db_estado = estado;
   assign db_canal  = canal;

   // Decode the received byte as a digit and validate it for each field
   always_comb begin
      digito   = rx_dado - C_0;
      canal_ok = rx_paridade_ok && (rx_dado >= C_0) && (digito < N_BITS'(N_CH));
      pos_ok   = rx_paridade_ok && (rx_dado >= C_0) && (digito < N_BITS'(N_POS));
   end

   // Shared PWM period counter
   always_ff @(posedge clock or negedge reset) begin
      if (!reset)
         conta <= '0;
      else if (vira)
         conta <= '0;
      else
         conta <= conta + W'(1);
   end

   // Command FSM with registered response, strobe and error flag
   always_ff @(posedge clock or negedge reset) begin
      if (!reset) begin
         estado     <= OCIOSO;
         canal      <= '0;
         pos        <= '0;
         tempo      <= '0;
         tx_dado    <= '0;
         tx_partida <= 1'b0;
         erro       <= 1'b0;
      end else begin
         tx_partida <= 1'b0;
         case (estado)
            OCIOSO: begin
               tempo <= '0;
               if (rx_fim) begin
                  if (canal_ok) begin
                     canal  <= digito[2:0];
                     estado <= ESPERA_POS;
                  end else begin
                     tx_dado <= C_E;
                     erro    <= 1'b1;
                     estado  <= ENVIA;
                  end
               end
            end
            ESPERA_POS: begin
               if (rx_fim) begin
                  tempo <= '0;
                  if (pos_ok) begin
                     pos    <= digito[3:0];
                     estado <= APLICA;
                  end else begin
                     tx_dado <= C_E;
                     erro    <= 1'b1;
                     estado  <= ENVIA;
                  end
               end else if (tempo == TW'(TIMEOUT - 1)) begin
                  tempo   <= '0;
                  tx_dado <= C_E;
                  erro    <= 1'b1;
                  estado  <= ENVIA;
               end else begin
                  tempo <= tempo + TW'(1);
               end
            end
            APLICA: begin
               tx_dado <= C_K;
               erro    <= 1'b0;
               estado  <= ENVIA;
            end
            ENVIA: begin
               if (tx_pronto) begin
                  tx_partida <= 1'b1;
                  estado     <= AGUARDA_TX;
               end
            end
            AGUARDA_TX: begin
               if (tx_pronto)
                  estado <= OCIOSO;
            end
            default: estado <= OCIOSO;
         endcase
      end
   end

   for (genvar i = 0; i < N_CH; i++) begin : g_canal
      pwm_canal #(
         .W        (W),
         .LARG_MIN (LARG_MIN)
      ) u_canal (
         .clock   (clock),
         .reset   (reset),
         .conta   (conta),
         .vira    (vira),
         .escreve (escreve && (canal == 3'(i))),
         .largura (largura),
         .pwm     (pwm[i])
      );
   end

endmodule
